// File: rtl/cl_sde_pix_pkg.sv
// Shared constants, register map and FSM state type for the SDE pixel stream transmitter.
package cl_sde_pix_pkg;

  localparam int unsigned PIX_W_DEF        = 16;
  localparam int unsigned PIX_PER_BEAT_DEF = 3;

  localparam logic [11:0] REG_CTRL    = 12'h000;
  localparam logic [11:0] REG_NUM_IMG = 12'h004;
  localparam logic [11:0] REG_WR_PTR  = 12'h008;
  localparam logic [11:0] REG_PIX_LO  = 12'h00C;
  localparam logic [11:0] REG_PIX_HI  = 12'h010;
  localparam logic [11:0] REG_STATUS  = 12'h014;
  localparam logic [11:0] REG_BEATS   = 12'h018;
  localparam logic [11:0] REG_TIMER   = 12'h01C;

  localparam logic [31:0] DEADBEEF = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StSend
  } state_e;

endpackage

// File: rtl/cl_sde_pix_tx_if.sv
// Host register port plus outgoing 512-bit stream of the pixel transmitter.
// master = host/sink side, slave = the transmitter block.
interface cl_sde_pix_tx_if;

  logic [11:0]  cfg_srm_addr;
  logic         cfg_srm_wr;
  logic         cfg_srm_rd;
  logic [31:0]  cfg_srm_wdata;
  logic         srm_cfg_ack;
  logic [31:0]  srm_cfg_rdata;

  logic         ots_valid;
  logic [511:0] ots_data;
  logic [63:0]  ots_keep;
  logic [63:0]  ots_user;
  logic         ots_last;
  logic         ots_ready;

  modport master (
    output cfg_srm_addr, cfg_srm_wr, cfg_srm_rd, cfg_srm_wdata,
    input  srm_cfg_ack, srm_cfg_rdata,
    input  ots_valid, ots_data, ots_keep, ots_user, ots_last,
    output ots_ready
  );

  modport slave (
    input  cfg_srm_addr, cfg_srm_wr, cfg_srm_rd, cfg_srm_wdata,
    output srm_cfg_ack, srm_cfg_rdata,
    output ots_valid, ots_data, ots_keep, ots_user, ots_last,
    input  ots_ready
  );

endinterface

// File: rtl/cl_sde_pix_buf.sv
// Image buffer: simple dual-port RAM, one write port, one read port with registered output.
module cl_sde_pix_buf #(
  parameter int unsigned Depth = 128,
  parameter int unsigned Width = 48
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(Depth)-1:0] i_waddr,
  input  logic [Width-1:0]         i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(Depth)-1:0] i_raddr,
  output logic [Width-1:0]         o_rdata
);

  logic [Width-1:0] r_mem [Depth];
  logic [Width-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/cl_sde_pix_tx.sv
// Host-loaded pixel image replayed NUM_IMG times as a 512-bit AXI stream.
// Optional cycle timer at 0x1C enabled by defining CL_SDE_PIX_TX_TIMER_EN.
module cl_sde_pix_tx
  import cl_sde_pix_pkg::*;
#(
  parameter int unsigned IMG_BEATS    = 128,
  parameter int unsigned PIX_W        = PIX_W_DEF,
  parameter int unsigned PIX_PER_BEAT = PIX_PER_BEAT_DEF
) (
  input logic            clk,
  input logic            rst_n,
  cl_sde_pix_tx_if.slave bus
);

  localparam int unsigned DW = PIX_W * PIX_PER_BEAT;
  localparam int unsigned AW = $clog2(IMG_BEATS);
  localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_BEATS - 1);

  state_e r_state, w_state_nxt;

  logic [15:0]     r_num_img;
  logic [AW-1:0]   r_wr_ptr;
  logic [2*PIX_W-1:0] r_stage;
  logic [15:0]     r_img_done;
  logic [31:0]     r_beats;
  logic            r_abort_pend;
  logic            r_ack;
  logic [31:0]     r_rdata;

  logic [AW-1:0]   r_rd_addr;
  logic            r_inflight;
  logic            r_if_last;
  logic [DW-1:0]   r_fifo_data [2];
  logic [1:0]      r_fifo_last;
  logic            r_wp, r_rp;
  logic [1:0]      r_cnt;

  logic            w_busy, w_issue_en, w_flush, w_finish;
  logic            w_wr_ctrl, w_go, w_abort, w_start, w_buf_we;
  logic            w_valid, w_hs, w_head_last, w_issue, w_push;
  logic [2:0]      w_occ;
  logic [16:0]     w_img_inc;
  logic [DW-1:0]   w_ram_rdata;
  logic [31:0]     w_rdata, w_timer;

  // Register port decode
  assign w_wr_ctrl = bus.cfg_srm_wr && (bus.cfg_srm_addr == REG_CTRL);
  assign w_go      = w_wr_ctrl && bus.cfg_srm_wdata[0];
  assign w_abort   = w_wr_ctrl && bus.cfg_srm_wdata[1];
  assign w_start   = w_go && !w_busy && (r_num_img != 16'd0);
  assign w_buf_we  = bus.cfg_srm_wr && (bus.cfg_srm_addr == REG_PIX_HI) && !w_busy;

  // Stream side
  assign w_valid     = (r_cnt != 2'd0);
  assign w_hs        = w_valid && bus.ots_ready;
  assign w_head_last = r_fifo_last[r_rp];
  assign w_img_inc   = {1'b0, r_img_done} + 17'd1;
  assign w_finish    = w_hs && w_head_last &&
                       ((w_img_inc >= {1'b0, r_num_img}) || r_abort_pend);

  // Reads in flight count against the 2-entry skid so the RAM latency never overflows it
  assign w_occ   = {1'b0, r_cnt} + {2'b00, r_inflight};
  assign w_issue = w_issue_en && (w_occ <= (3'd1 + {2'b00, w_hs}));
  assign w_push  = r_inflight && !w_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_start) w_state_nxt = StFetch;
      StFetch: w_state_nxt = StSend;
      StSend:  if (w_finish) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    w_busy     = 1'b1;
    w_issue_en = 1'b0;
    w_flush    = 1'b0;
    unique case (r_state)
      StIdle:  w_busy = 1'b0;
      StFetch: w_issue_en = 1'b1;
      StSend: begin
        w_issue_en = !w_finish;
        w_flush    = w_finish;
      end
      default: w_busy = 1'b0;
    endcase
  end

  cl_sde_pix_buf #(
    .Depth (IMG_BEATS),
    .Width (DW)
  ) u_buf (
    .clk     (clk),
    .i_we    (w_buf_we),
    .i_waddr (r_wr_ptr),
    .i_wdata ({bus.cfg_srm_wdata[PIX_W-1:0], r_stage}),
    .i_re    (w_issue),
    .i_raddr (r_rd_addr),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_addr  <= '0;
      r_inflight <= 1'b0;
      r_if_last  <= 1'b0;
    end else begin
      if (w_start) begin
        r_rd_addr <= '0;
      end else if (w_issue) begin
        r_rd_addr <= r_rd_addr + 1'b1;
      end
      r_inflight <= w_issue;
      if (w_issue) begin
        r_if_last <= (r_rd_addr == LAST_ADDR);
      end
    end
  end

  // Final tlast of a run discards any prefetched beats of the following image
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_fifo_data[i] <= '0;
      end
      r_fifo_last <= '0;
      r_wp        <= 1'b0;
      r_rp        <= 1'b0;
      r_cnt       <= '0;
    end else if (w_flush) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wp] <= w_ram_rdata;
        r_fifo_last[r_wp] <= r_if_last;
        r_wp              <= ~r_wp;
      end
      if (w_hs) begin
        r_rp <= ~r_rp;
      end
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_hs};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_img_done   <= '0;
      r_beats      <= '0;
      r_abort_pend <= 1'b0;
    end else begin
      if (w_start) begin
        r_img_done <= '0;
        r_beats    <= '0;
      end else if (w_hs) begin
        if (r_beats != 32'hFFFF_FFFF) r_beats <= r_beats + 32'd1;
        if (w_head_last && (r_img_done != 16'hFFFF)) r_img_done <= r_img_done + 16'd1;
      end
      if (w_start || w_flush) begin
        r_abort_pend <= 1'b0;
      end else if (w_abort && w_busy) begin
        r_abort_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num_img <= '0;
      r_wr_ptr  <= '0;
      r_stage   <= '0;
    end else if (bus.cfg_srm_wr) begin
      if (bus.cfg_srm_addr == REG_NUM_IMG) r_num_img <= bus.cfg_srm_wdata[15:0];
      if (bus.cfg_srm_addr == REG_WR_PTR)  r_wr_ptr  <= bus.cfg_srm_wdata[AW-1:0];
      if ((bus.cfg_srm_addr == REG_PIX_LO) && !w_busy) r_stage <= bus.cfg_srm_wdata[2*PIX_W-1:0];
      if (w_buf_we) r_wr_ptr <= r_wr_ptr + 1'b1;
    end
  end

`ifdef CL_SDE_PIX_TX_TIMER_EN
  logic [31:0] r_timer;
  logic        r_tmr_run;

  // Runs from the first valid of a run through the final tlast handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer   <= '0;
      r_tmr_run <= 1'b0;
    end else if (w_start) begin
      r_timer   <= '0;
      r_tmr_run <= 1'b0;
    end else if (w_busy && (w_valid || r_tmr_run)) begin
      r_tmr_run <= 1'b1;
      if (r_timer != 32'hFFFF_FFFF) r_timer <= r_timer + 32'd1;
    end
  end

  assign w_timer = r_timer;
`else
  assign w_timer = '0;
`endif

  always_comb begin
    w_rdata = DEADBEEF;
    case (bus.cfg_srm_addr)
      REG_CTRL, REG_PIX_LO, REG_PIX_HI: w_rdata = '0;
      REG_NUM_IMG: w_rdata = {16'd0, r_num_img};
      REG_WR_PTR:  w_rdata = 32'(r_wr_ptr);
      REG_STATUS:  w_rdata = {r_img_done, 14'd0, r_abort_pend, w_busy};
      REG_BEATS:   w_rdata = r_beats;
      REG_TIMER:   w_rdata = w_timer;
      default:     w_rdata = DEADBEEF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack <= bus.cfg_srm_wr || bus.cfg_srm_rd;
      if (bus.cfg_srm_rd) r_rdata <= w_rdata;
    end
  end

  assign bus.srm_cfg_ack   = r_ack;
  assign bus.srm_cfg_rdata = r_rdata;
  assign bus.ots_valid     = w_valid;
  assign bus.ots_data      = {{(512 - DW){1'b0}}, r_fifo_data[r_rp]};
  assign bus.ots_keep      = {64{w_valid}};
  assign bus.ots_user      = {48'd0, r_img_done};
  assign bus.ots_last      = w_valid && w_head_last;

endmodule
